// File: rtl/axi_rd_checker.sv
// Passive AXI4 read-channel protocol checker: keeps accepted AR requests in order
// and checks each R burst against the oldest outstanding request.
module axi_rd_checker #(
    parameter int AWID_WIDTH      = 4,
    parameter int AWADDR_WIDTH    = 32,
    parameter int WDATA_WIDTH     = 64,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   chk_en,
    input  logic                                   clr,
    input  logic [AWID_WIDTH-1:0]                  ARID,
    input  logic [AWADDR_WIDTH-1:0]                ARADDR,
    input  logic [7:0]                             ARLEN,
    input  logic [2:0]                             ARSIZE,
    input  logic [1:0]                             ARBURST,
    input  logic [3:0]                             ARREGION,
    input  logic                                   ARVALID,
    input  logic                                   ARREADY,
    input  logic [AWID_WIDTH-1:0]                  RID,
    input  logic [WDATA_WIDTH-1:0]                 RDATA,
    input  logic [1:0]                             RRESP,
    input  logic                                   RLAST,
    input  logic                                   RVALID,
    input  logic                                   RREADY,
    output logic [6:0]                             err_pulse,
    output logic [6:0]                             err_sticky,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   burst_done,
    output logic [CNT_WIDTH-1:0]                   burst_cnt
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int AR_PW = AWID_WIDTH + AWADDR_WIDTH + 8 + 3 + 2 + 4;
    localparam int R_PW  = AWID_WIDTH + WDATA_WIDTH + 2 + 1;

    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0]     OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [AWID_WIDTH-1:0] q_id_r  [MAX_OUTSTANDING];
    logic [7:0]            q_len_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [OCC_W-1:0]      count_r;
    logic [7:0]            beat_cnt_r;

    logic                  ar_stall_r;
    logic [AR_PW-1:0]      ar_payload_r;
    logic                  r_stall_r;
    logic [R_PW-1:0]       r_payload_r;

    logic                  ar_hs_s;
    logic                  r_hs_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  beat_ok_s;
    logic                  len_hit_s;
    logic                  pop_s;
    logic                  push_s;
    logic [AWID_WIDTH-1:0] head_id_s;
    logic [7:0]            head_len_s;
    logic [AR_PW-1:0]      ar_payload_s;
    logic [R_PW-1:0]       r_payload_s;
    logic [6:0]            err_s;
    logic [6:0]            err_chk_s;

    assign ar_hs_s      = ARVALID & ARREADY;
    assign r_hs_s       = RVALID & RREADY;
    assign empty_s      = (count_r == {OCC_W{1'b0}});
    assign full_s       = (count_r == OCC_FULL);
    assign head_id_s    = q_id_r[rd_ptr_r];
    assign head_len_s   = q_len_r[rd_ptr_r];
    assign beat_ok_s    = r_hs_s & ~empty_s;
    assign len_hit_s    = (beat_cnt_r == head_len_s);
    assign pop_s        = beat_ok_s & (RLAST | len_hit_s);
    // A pop on the same edge frees the slot the new request lands in.
    assign push_s       = ar_hs_s & (~full_s | pop_s);
    assign ar_payload_s = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION};
    assign r_payload_s  = {RID, RDATA, RRESP, RLAST};
    assign outstanding  = count_r;

    // Error classification for the current edge, masked by chk_en.
    always_comb begin
        err_s    = 7'b0;
        err_s[0] = ar_stall_r & (~ARVALID | (ar_payload_s != ar_payload_r));
        err_s[1] = r_stall_r & (~RVALID | (r_payload_s != r_payload_r));
        err_s[2] = r_hs_s & empty_s;
        err_s[3] = beat_ok_s & (RID != head_id_s);
        err_s[4] = beat_ok_s & RLAST & (beat_cnt_r < head_len_s);
        err_s[5] = beat_ok_s & len_hit_s & ~RLAST;
        err_s[6] = ar_hs_s & full_s & ~pop_s;
        if (chk_en) begin
            err_chk_s = err_s;
        end else begin
            err_chk_s = 7'b0;
        end
    end

    // In-order request queue, occupancy and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_id_r[i]  <= {AWID_WIDTH{1'b0}};
                q_len_r[i] <= 8'd0;
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {OCC_W{1'b0}};
            beat_cnt_r <= 8'd0;
        end else begin
            if (push_s) begin
                q_id_r[wr_ptr_r]  <= ARID;
                q_len_r[wr_ptr_r] <= ARLEN;
                wr_ptr_r          <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + OCC_ONE;
                2'b01:   count_r <= count_r - OCC_ONE;
                default: count_r <= count_r;
            endcase
            if (pop_s) begin
                beat_cnt_r <= 8'd0;
            end else if (beat_ok_s) begin
                beat_cnt_r <= beat_cnt_r + 8'd1;
            end
        end
    end

    // Handshake history used by the payload-stability checks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_stall_r   <= 1'b0;
            ar_payload_r <= {AR_PW{1'b0}};
            r_stall_r    <= 1'b0;
            r_payload_r  <= {R_PW{1'b0}};
        end else begin
            ar_stall_r   <= ARVALID & ~ARREADY;
            ar_payload_r <= ar_payload_s;
            r_stall_r    <= RVALID & ~RREADY;
            r_payload_r  <= r_payload_s;
        end
    end

    // Reported status: error pulses, sticky errors and burst completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse  <= 7'b0;
            err_sticky <= 7'b0;
            burst_done <= 1'b0;
            burst_cnt  <= {CNT_WIDTH{1'b0}};
        end else begin
            err_pulse  <= err_chk_s;
            burst_done <= pop_s;
            if (clr) begin
                err_sticky <= err_chk_s;
                burst_cnt  <= {CNT_WIDTH{1'b0}};
            end else begin
                err_sticky <= err_sticky | err_chk_s;
                if (pop_s) begin
                    burst_cnt <= burst_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: doc/axi_rd_checker.md
Name: axi_rd_checker

Overview:
- Passive, parametrised AXI4 read-channel protocol checker; sits beside the AR/R bus in the verification top and drives nothing onto the bus.
- Records accepted AR requests in an in-order queue and matches R bursts against the queue head.
- Checks ID, beat count, RLAST placement, payload stability under backpressure, and queue overflow.
- Reports per-cycle error pulses, sticky errors, outstanding depth and completed-burst count.

Parameters:
AWID_WIDTH, 4, width of ARID/RID
AWADDR_WIDTH, 32, width of ARADDR
WDATA_WIDTH, 64, width of RDATA
MAX_OUTSTANDING, 8, AR queue depth; power of two, >=2
CNT_WIDTH, 16, width of burst_cnt

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
chk_en  input  1  1 = errors reported; 0 = queue still tracks, err_pulse forced 0
clr  input  1  synchronous clear of err_sticky and burst_cnt
ARID  input  AWID_WIDTH  AR ID
ARADDR  input  AWADDR_WIDTH  AR address
ARLEN  input  8  beats-1
ARSIZE  input  3  beat size
ARBURST  input  2  burst type
ARREGION  input  4  region
ARVALID  input  1  AR valid
ARREADY  input  1  AR ready
RID  input  AWID_WIDTH  R ID
RDATA  input  WDATA_WIDTH  R data
RRESP  input  2  R response
RLAST  input  1  last beat
RVALID  input  1  R valid
RREADY  input  1  R ready
err_pulse  output  7  per-cycle error flags, registered
err_sticky  output  7  OR-accumulated err_pulse
outstanding  output  $clog2(MAX_OUTSTANDING+1)  queue occupancy
burst_done  output  1  one-cycle pulse per completed R burst
burst_cnt  output  CNT_WIDTH  completed bursts, wraps at 2^CNT_WIDTH

Behaviour:
- Reset (rst_n low, async): queue empty, beat counter 0, all outputs 0, stability history cleared.
- AR handshake = ARVALID&ARREADY at a clock edge. Push {ARID, ARLEN} if the queue is not full.
- R beat = RVALID&RREADY. Each R beat is checked against the head entry as registered before that edge. A same-edge AR push is not visible to a same-edge R beat.
- Beat counter counts accepted beats of the current head burst; it is compared against head ARLEN.
- err_pulse bits, asserted in the cycle after the offending edge:
  - [0] AR payload (ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARREGION) changed, or ARVALID dropped, while previous cycle had ARVALID&!ARREADY.
  - [1] R payload (RID/RDATA/RRESP/RLAST) changed, or RVALID dropped, while previous cycle had RVALID&!RREADY.
  - [2] orphan: R beat with queue empty. Beat is ignored; counter unchanged.
  - [3] RID != head ID.
  - [4] early RLAST: RLAST=1 with beat counter < head ARLEN.
  - [5] missing RLAST: beat counter == head ARLEN and RLAST=0.
  - [6] overflow: AR handshake while queue full. Request is dropped.
- Burst completion: on a non-orphan beat with RLAST=1 or beat counter==ARLEN, pop the head, clear the beat counter, pulse burst_done and increment burst_cnt. Early and missing RLAST therefore both terminate the burst.
- Bits [3] and [4]/[5] can co-assert. All bits are independent and may set in the same cycle.
- Simultaneous push and pop: occupancy unchanged. Full queue plus pop plus AR on the same edge is not an overflow, because the pop frees a slot.
- chk_en=0: err_pulse=0 and err_sticky holds; queue, burst_done and burst_cnt still operate.
- clr: err_sticky and burst_cnt go to 0 next cycle. A same-cycle new error wins, so its err_sticky bit is set.
- RRESP value is not checked here.

Test Plan:
- AR{ID=3, LEN=3} accepted, then 4 R beats RID=3 with RLAST on beat 4 -> burst_done single pulse, burst_cnt=1, outstanding 1->0, err_sticky=0.
- AR{LEN=3}, RLAST on beat 2 -> err_pulse[4] one cycle, entry popped, outstanding=0; next R beat -> err_pulse[2].
- ARVALID=1, ARREADY=0 for 2 cycles, ARADDR changes 0x100->0x104 -> err_pulse[0]=1; same sequence with stable address -> no error.
- MAX_OUTSTANDING=8: 8 ARs accepted with no R, 9th AR handshake -> err_pulse[6], outstanding stays 8; repeat on a cycle where an RLAST pops -> no error, outstanding 8.
- Two ARs ID=1 then ID=2; R burst with RID=2 first -> err_pulse[3] on each beat; bursts still complete in queue order, burst_cnt=2.
- Assert rst_n low mid-burst (beat 2 of 4) -> all outputs 0 immediately; fresh AR/R sequence afterwards completes cleanly.
